qtr_rc_timer: RTL and testbench
===============================

QTR_RC_TIMER -- requirements
Module: qtr_rc_timer

Interface
REQ-001 Parameter NCH, default 8: number of QTR sensor channels.
REQ-002 Parameter CHARGE_CYCLES, default 500: clocks the sensor lines are driven high (10 us at 50 MHz).
REQ-003 Parameter TICK_DIV, default 50: clocks per measurement tick (1 us at 50 MHz).
REQ-004 Parameter TIMEOUT, default 2500: maximum ticks measured; must be at most 4095.
REQ-005 Port clk, input, 1: single system clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port st_bt, input, 1: start/hold level from the position FSM.
REQ-008 Port sen_in, input, NCH: raw sensor pin levels, asynchronous to clk.
REQ-009 Port sen_oe, output, 1: pad output-enable for all sensor pins.
REQ-010 Port sen_out, output, 1: pad drive value for all sensor pins.
REQ-011 Port times, output, NCH*12: per-channel discharge tick counts; channel i is at bits [12i+11:12i].
REQ-012 Port eo_bt, output, 1: measurement-complete level.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, CHARGE, MEASURE and DONE.
REQ-014 IDLE: sen_oe=0, sen_out=0, eo_bt=0; the FSM SHALL go to CHARGE on the clock edge where st_bt=1.
REQ-015 CHARGE: sen_oe=1, sen_out=1 for exactly CHARGE_CYCLES clocks.
- On CHARGE entry, all per-channel done flags, the tick prescaler and the elapsed counter SHALL be cleared.
- The FSM then goes to MEASURE.
REQ-016 MEASURE: sen_oe=0; the prescaler SHALL count 0..TICK_DIV-1 and increment the 12-bit elapsed counter on wrap.
REQ-017 sen_in SHALL pass through a 2-flop synchronizer; only the synchronized value is used.
REQ-018 In MEASURE, on the first clock where a not-done channel's synchronized input is 0:
- its times field SHALL load the current elapsed value;
- its done flag SHALL be set.
REQ-019 Leaving MEASURE:
- MEASURE SHALL exit when all NCH done flags are set, or when elapsed == TIMEOUT.
- On timeout exit, every not-done channel's field SHALL load TIMEOUT in the same clock.
REQ-020 If a channel falls in the same clock as the timeout, the elapsed value (equal to TIMEOUT) SHALL be captured; there is no double write.
REQ-021 DONE: eo_bt=1, held until st_bt=0 is sampled; then go to IDLE with eo_bt=0 on the next clock.
REQ-022 st_bt deasserting during CHARGE or MEASURE SHALL be ignored; the measurement completes and the FSM enters DONE.
- A start SHALL only be accepted in IDLE.
REQ-023 times SHALL be stable from eo_bt rise until the next CHARGE entry, so the downstream hold/latch pulse captures a consistent set.
REQ-024 The elapsed counter SHALL saturate at TIMEOUT and never wrap.
REQ-025 Latency from st_bt sampled high to eo_bt=1 SHALL be 1 + CHARGE_CYCLES + measure clocks + 1, with measure clocks at most TIMEOUT*TICK_DIV + 1.

Reset
REQ-026 On rst=1, asynchronously:
- FSM to IDLE;
- sen_oe=0, sen_out=0, eo_bt=0;
- times all 0;
- done flags, prescaler, elapsed counter and synchronizer flops cleared.
REQ-027 Reset asserted mid-CHARGE or mid-MEASURE SHALL release the pads immediately (sen_oe=0) and discard the partial results.

Structure
REQ-028 A shared package SHALL hold:
- the state encoding constants (IDLE=2'b00, CHARGE=2'b01, MEASURE=2'b10, DONE=2'b11);
- the 12-bit count width constant;
- the default CHARGE_CYCLES, TICK_DIV and TIMEOUT values.
REQ-029 The NCH-wide 2-flop synchronizer SHALL be a separate sub-module, sync_2ff, with clk and rst ports.

Verification
REQ-030 Reset: assert rst mid-CHARGE -> sen_oe=0 in the same cycle, times=0, eo_bt=0; after release, the block idles until st_bt=1.
REQ-031 Basic timing: st_bt=1; channel i input falls 100*(i+1) ticks after MEASURE entry -> field i = 100*(i+1) (±1 for synchronizer/prescaler phase); eo_bt rises after channel 7; times stable until st_bt drops.
REQ-032 Timeout: channels 3 and 5 never fall, others fall at 200 ticks -> fields 3 and 5 = 2500, others = 200; eo_bt rises 1 clock after elapsed reaches 2500.
REQ-033 Handshake: hold st_bt=1 through DONE -> eo_bt stays 1 and no restart occurs; drop st_bt -> IDLE next clock, eo_bt=0; re-raise st_bt -> new CHARGE of 500 clocks.
REQ-034 Early discharge: all inputs low from CHARGE end -> all fields = 0 and eo_bt asserted within 4 clocks of MEASURE entry.
REQ-035 Glitch: channel 2 pulses low for one clock at tick 50, then stays high -> field 2 = 50; a later fall of channel 2 is ignored.

Source files
------------

// File: rtl/qtr_rc_timer_pkg.sv
// Shared definitions for the QTR RC discharge timer: FSM encoding,
// measurement count width and default timing parameters.
package qtr_rc_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CHARGE  = 2'b01,
        MEASURE = 2'b10,
        DONE    = 2'b11
    } state_t;

    // Width of each per-channel tick count and of the elapsed counter.
    localparam int CNT_W = 12;

    // Defaults for a 50 MHz clock: 10 us charge, 1 us tick, 2.5 ms timeout.
    localparam int DEF_CHARGE_CYCLES = 500;
    localparam int DEF_TICK_DIV      = 50;
    localparam int DEF_TIMEOUT       = 2500;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous levels.
module sync_2ff #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_p0;
    logic [W-1:0] stage_p1;

    // Metastability filter: first flop may go metastable, second settles it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_p0 <= '0;
            stage_p1 <= '0;
        end else begin
            stage_p0 <= d;
            stage_p1 <= stage_p0;
        end
    end

    assign q = stage_p1;

endmodule

// File: rtl/qtr_rc_timer.sv
// QTR reflectance sensor RC timer: charges all sensor lines, then measures
// per-channel discharge time in ticks, with a shared timeout.
module qtr_rc_timer
    import qtr_rc_timer_pkg::*;
#(
    parameter int NCH           = 8,
    parameter int CHARGE_CYCLES = DEF_CHARGE_CYCLES,
    parameter int TICK_DIV      = DEF_TICK_DIV,
    parameter int TIMEOUT       = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 st_bt,
    input  logic [NCH-1:0]       sen_in,
    output logic                 sen_oe,
    output logic                 sen_out,
    output logic [NCH*CNT_W-1:0] times,
    output logic                 eo_bt
);

    localparam int CHG_W = $clog2(CHARGE_CYCLES + 1);
    localparam int PRE_W = $clog2(TICK_DIV + 1);

    localparam logic [CHG_W-1:0] CHG_LAST = CHG_W'(CHARGE_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);

    state_t             state;
    state_t             state_nxt;
    logic [CHG_W-1:0]   chg_cnt;
    logic [PRE_W-1:0]   presc;
    logic [CNT_W-1:0]   elapsed;
    logic [NCH-1:0]     done;
    logic [NCH-1:0]     sen_sync;
    logic [NCH-1:0]     fall;
    logic               all_done;
    logic               timeout;

    sync_2ff #(
        .W (NCH)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sen_in),
        .q   (sen_sync)
    );

    // A channel is captured the first clock its synchronized line reads low.
    assign fall     = ~done & ~sen_sync;
    assign all_done = &(done | fall);
    assign timeout  = (elapsed == TMO);

    // State register; reset releases the pads immediately via IDLE outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and pad/handshake outputs decoded from the current state.
    always_comb begin
        state_nxt = state;
        sen_oe    = 1'b0;
        sen_out   = 1'b0;
        eo_bt     = 1'b0;
        case (state)
            IDLE: begin
                if (st_bt) state_nxt = CHARGE;
            end
            CHARGE: begin
                sen_oe  = 1'b1;
                sen_out = 1'b1;
                if (chg_cnt == CHG_LAST) state_nxt = MEASURE;
            end
            MEASURE: begin
                if (all_done || timeout) state_nxt = DONE;
            end
            DONE: begin
                eo_bt = 1'b1;
                if (!st_bt) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Charge timer, tick prescaler, elapsed counter and per-channel capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chg_cnt <= '0;
            presc   <= '0;
            elapsed <= '0;
            done    <= '0;
            times   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (st_bt) begin
                        chg_cnt <= '0;
                        presc   <= '0;
                        elapsed <= '0;
                        done    <= '0;
                    end
                end
                CHARGE: begin
                    chg_cnt <= chg_cnt + CHG_W'(1);
                end
                MEASURE: begin
                    if (presc == PRE_LAST) begin
                        presc <= '0;
                        if (!timeout) elapsed <= elapsed + CNT_W'(1);
                    end else begin
                        presc <= presc + PRE_W'(1);
                    end
                    // A fall on the timeout clock captures elapsed, which equals TMO.
                    for (int i = 0; i < NCH; i++) begin
                        if (fall[i]) begin
                            times[i*CNT_W +: CNT_W] <= elapsed;
                            done[i]                 <= 1'b1;
                        end else if (timeout && !done[i]) begin
                            times[i*CNT_W +: CNT_W] <= TMO;
                            done[i]                 <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qtr_rc_timer.sv
// Self-checking bench for qtr_rc_timer: a timeline model predicts pad,
// handshake and result values for every clock of each measurement.
module tb_qtr_rc_timer;

    localparam int NCH  = 8;
    localparam int CHG  = 500;
    localparam int TDIV = 4;
    localparam int TMO  = 2500;
    localparam int KTO  = TMO * TDIV;

    logic            clk = 1'b0;
    logic            rst;
    logic            st_bt;
    logic [NCH-1:0]  sen_in;
    logic            sen_oe;
    logic            sen_out;
    logic [NCH*12-1:0] times;
    logic            eo_bt;

    always #5 clk = ~clk;

    qtr_rc_timer #(
        .NCH           (NCH),
        .CHARGE_CYCLES (CHG),
        .TICK_DIV      (TDIV),
        .TIMEOUT       (TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .st_bt   (st_bt),
        .sen_in  (sen_in),
        .sen_oe  (sen_oe),
        .sen_out (sen_out),
        .times   (times),
        .eo_bt   (eo_bt)
    );

    int   tests = 0;
    int   fails = 0;
    logic chk_en    = 1'b0;
    logic exp_oe    = 1'b0;
    logic exp_out   = 1'b0;
    logic exp_eo    = 1'b0;
    logic times_chk = 1'b0;
    int   exp_t[NCH];

    // Stimulus per channel, in clocks after MEASURE entry: permanent fall
    // start f, single-clock low glitch g; -1 means none.
    int f[NCH];
    int g[NCH];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fld(input int i);
        return int'(times[i*12 +: 12]);
    endfunction

    function automatic logic level(input int i, input int j);
        if (j < 0) return 1'b1;
        if (f[i] >= 0 && j >= f[i]) return 1'b0;
        if (j == g[i]) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sen_oe", int'(sen_oe), int'(exp_oe));
            chk("sen_out", int'(sen_out), int'(exp_out));
            chk("eo_bt", int'(eo_bt), int'(exp_eo));
            if (times_chk) begin
                for (int i = 0; i < NCH; i++)
                    chk($sformatf("times[%0d]", i), fld(i), exp_t[i]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One full measurement from IDLE, ending back in IDLE with st_bt low.
    task automatic measure(input int hold);
        int det[NCH];
        int val[NCH];
        int worst;
        int kend;
        worst = 0;
        for (int i = 0; i < NCH; i++) begin
            // Synchronized level lags the pin by two clocks.
            det[i] = KTO + 1;
            if (g[i] >= 0) det[i] = g[i] + 2;
            if (f[i] >= 0 && f[i] + 2 < det[i]) det[i] = f[i] + 2;
            if (det[i] > KTO) det[i] = KTO + 1;
            val[i] = (det[i] > KTO) ? TMO : det[i] / TDIV;
            if (det[i] > worst) worst = det[i];
        end
        kend = (worst > KTO) ? KTO : worst;

        st_bt = 1'b1;
        cyc();
        exp_oe = 1'b1; exp_out = 1'b1; exp_eo = 1'b0; times_chk = 1'b0;
        sen_in = '1;
        for (int c = 0; c < CHG; c++) begin
            if (c > 0) cyc();
            st_bt = 1'($urandom_range(0, 1));
        end
        for (int k = 0; k <= kend; k++) begin
            cyc();
            exp_oe = 1'b0; exp_out = 1'b0;
            for (int i = 0; i < NCH; i++) sen_in[i] = level(i, k);
            st_bt = 1'($urandom_range(0, 1));
        end
        cyc();
        exp_eo = 1'b1;
        st_bt  = 1'b1;
        for (int i = 0; i < NCH; i++) exp_t[i] = val[i];
        times_chk = 1'b1;
        for (int h = 0; h < hold; h++) begin
            cyc();
            sen_in = NCH'($urandom);
        end
        st_bt = 1'b0;
        cyc();
        exp_eo = 1'b0;
        sen_in = '1;
        repeat (3) cyc();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        st_bt  = 1'b0;
        sen_in = '1;
        for (int i = 0; i < NCH; i++) begin
            exp_t[i] = 0; f[i] = -1; g[i] = -1;
        end
        repeat (3) cyc();
        chk("rst_sen_oe", int'(sen_oe), 0);
        chk("rst_eo_bt", int'(eo_bt), 0);
        chk("rst_times", (times == '0) ? 1 : 0, 1);
        #2 rst = 1'b0;
        times_chk = 1'b1;
        chk_en    = 1'b1;
        repeat (5) cyc();

        // Staggered falls at 100*(i+1) ticks, long DONE hold.
        for (int i = 0; i < NCH; i++) begin f[i] = 100 * (i + 1) * TDIV; g[i] = -1; end
        measure(10);
        for (int i = 0; i < NCH; i++) chk($sformatf("lit_basic[%0d]", i), fld(i), 100 * (i + 1));

        // Reset in the middle of CHARGE.
        st_bt = 1'b1;
        cyc();
        exp_oe = 1'b1; exp_out = 1'b1; times_chk = 1'b0;
        st_bt = 1'b0;
        repeat (100) cyc();
        chk_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_sen_oe", int'(sen_oe), 0);
        chk("midrst_sen_out", int'(sen_out), 0);
        chk("midrst_eo_bt", int'(eo_bt), 0);
        for (int i = 0; i < NCH; i++) chk($sformatf("midrst_times[%0d]", i), fld(i), 0);
        cyc();
        #2 rst = 1'b0;
        exp_oe = 1'b0; exp_out = 1'b0; exp_eo = 1'b0;
        for (int i = 0; i < NCH; i++) exp_t[i] = 0;
        times_chk = 1'b1;
        chk_en    = 1'b1;
        repeat (10) cyc();

        // Timeout: channels 3 and 5 never discharge.
        for (int i = 0; i < NCH; i++) begin f[i] = 200 * TDIV; g[i] = -1; end
        f[3] = -1; f[5] = -1;
        measure(2);
        for (int i = 0; i < NCH; i++)
            chk($sformatf("lit_tmo[%0d]", i), fld(i), (i == 3 || i == 5) ? 2500 : 200);

        // Early discharge: all lines low from MEASURE entry.
        for (int i = 0; i < NCH; i++) begin f[i] = 0; g[i] = -1; end
        measure(0);
        for (int i = 0; i < NCH; i++) chk($sformatf("lit_early[%0d]", i), fld(i), 0);

        // One-clock glitch on channel 2 at tick 50, later real fall ignored.
        for (int i = 0; i < NCH; i++) begin f[i] = 100 * TDIV; g[i] = -1; end
        g[2] = 50 * TDIV; f[2] = 300 * TDIV;
        measure(1);
        chk("lit_glitch", fld(2), 50);
        chk("lit_glitch_other", fld(0), 100);

        // Randomized measurements.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NCH; i++) begin
                f[i] = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 600 * TDIV));
                g[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 600 * TDIV)) : -1;
            end
            measure(int'($urandom_range(0, 6)));
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
